// File: rtl/multi_alien_renderer_pkg.sv
// Shared types, defaults and helpers for the multi-alien sprite address renderer.
package multi_alien_renderer_pkg;

    localparam int unsigned MAX_HALF_DEF   = 32;
    localparam int unsigned ADDR_W_DEF     = 11;
    localparam int unsigned RENDER_LATENCY = 3;

    typedef struct packed {
        logic [9:0] _x_pos;
        logic [9:0] _y_pos;
        logic [5:0] _r;
        logic [1:0] _deriv_left;
        logic [1:0] _deriv_right;
    } alien_data_t;

    // Per-channel S1 result; dx/dy/hw are only meaningful when hit is set.
    typedef struct packed {
        logic       hit;
        logic [5:0] dx;
        logic [6:0] dy;
        logic [5:0] hw;
        logic [1:0] deriv;
        logic [5:0] r;
    } alien_hit_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alien_hit_unit.sv
// Combinational hit test of one pixel against one alien descriptor.
// ALIEN_DEPTH_SORT_EN selects whether the depth key (_r) is forwarded.
module alien_hit_unit
    import multi_alien_renderer_pkg::*;
#(
    parameter int unsigned MAX_HALF = MAX_HALF_DEF
) (
    input  alien_data_t desc,
    input  logic        active,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output alien_hit_t  hit
);

    logic [9:0]         hw;
    logic [9:0]         dx;
    logic               right;
    logic               visible;
    logic               h_hit;
    logic               v_hit;
    logic signed [11:0] top;
    logic signed [11:0] dy;

    always_comb begin
        hw      = 10'(MAX_HALF) - {4'b0, desc._r};
        visible = active && ({4'b0, desc._r} < 10'(MAX_HALF));
        right   = h_cnt >= desc._x_pos;
        dx      = right ? (h_cnt - desc._x_pos) : (desc._x_pos - h_cnt);
        h_hit   = dx < hw;
        // Signed top edge: sprites overlapping row 0 are clipped, not wrapped.
        top     = $signed({2'b00, desc._y_pos}) - $signed({2'b00, hw});
        dy      = $signed({2'b00, v_cnt}) - top;
        v_hit   = !dy[11] && (dy < $signed({1'b0, hw, 1'b0}));

        hit       = '0;
        hit.hit   = visible && h_hit && v_hit;
        hit.dx    = dx[5:0];
        hit.dy    = dy[6:0];
        hit.hw    = hw[5:0];
        hit.deriv = right ? desc._deriv_right : desc._deriv_left;
`ifdef ALIEN_DEPTH_SORT_EN
        hit.r     = desc._r;
`else
        // Equal keys make the winner scan a plain lowest-index priority encoder.
        hit.r     = '0;
`endif
    end

endmodule

// File: rtl/multi_alien_renderer.sv
// Three-stage sprite-address generator choosing one alien per pixel.
// ALIEN_DEPTH_SORT_EN: winner is the hitting channel with the smallest _r.
module multi_alien_renderer
    import multi_alien_renderer_pkg::*;
#(
    parameter int unsigned N_ALIENS = 8,
    parameter int unsigned MAX_HALF = MAX_HALF_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_start,
    input  alien_data_t                       alien_data [N_ALIENS],
    input  logic [N_ALIENS-1:0]               alien_active,
    input  logic [9:0]                        h_cnt,
    input  logic [9:0]                        v_cnt,
    output logic [ADDR_W-1:0]                 pixel_addr,
    output logic [1:0]                        deriv_select,
    output logic [id_width(N_ALIENS)-1:0]     alien_id,
    output logic                              valid
);

    localparam int unsigned IdW = id_width(N_ALIENS);

    alien_data_t         shadow_data [N_ALIENS];
    logic [N_ALIENS-1:0] shadow_active;
    alien_hit_t          hit_c [N_ALIENS];
    alien_hit_t          s1_q  [N_ALIENS];

    logic           win_found;
    logic [IdW-1:0] win_idx;
    logic [5:0]     win_dx;
    logic [6:0]     win_dy;
    logic [5:0]     win_hw;
    logic [1:0]     win_deriv;
    logic [5:0]     win_r;

    logic           s2_valid_q;
    logic [IdW-1:0] s2_idx_q;
    logic [5:0]     s2_dx_q;
    logic [6:0]     s2_dy_q;
    logic [5:0]     s2_hw_q;
    logic [1:0]     s2_deriv_q;
    logic [12:0]    addr_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_active <= '0;
            for (int i = 0; i < N_ALIENS; i++) shadow_data[i] <= '0;
        end else if (frame_start) begin
            shadow_active <= alien_active;
            for (int i = 0; i < N_ALIENS; i++) shadow_data[i] <= alien_data[i];
        end
    end

    for (genvar g = 0; g < N_ALIENS; g++) begin : g_hit
        alien_hit_unit #(
            .MAX_HALF (MAX_HALF)
        ) u_hit (
            .desc   (shadow_data[g]),
            .active (shadow_active[g]),
            .h_cnt  (h_cnt),
            .v_cnt  (v_cnt),
            .hit    (hit_c[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALIENS; i++) s1_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_ALIENS; i++) s1_q[i] <= hit_c[i];
        end
    end

    // Strict less-than keeps ties on the lower index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_dx    = '0;
        win_dy    = '0;
        win_hw    = '0;
        win_deriv = '0;
        win_r     = '0;
        for (int i = 0; i < N_ALIENS; i++) begin
            if (s1_q[i].hit && (!win_found || (s1_q[i].r < win_r))) begin
                win_found = 1'b1;
                win_idx   = IdW'(i);
                win_dx    = s1_q[i].dx;
                win_dy    = s1_q[i].dy;
                win_hw    = s1_q[i].hw;
                win_deriv = s1_q[i].deriv;
                win_r     = s1_q[i].r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_dx_q    <= '0;
            s2_dy_q    <= '0;
            s2_hw_q    <= '0;
            s2_deriv_q <= '0;
        end else begin
            s2_valid_q <= win_found;
            s2_idx_q   <= win_idx;
            s2_dx_q    <= win_dx;
            s2_dy_q    <= win_dy;
            s2_hw_q    <= win_hw;
            s2_deriv_q <= win_deriv;
        end
    end

    always_comb begin
        addr_full = 13'(s2_dy_q) * 13'(s2_hw_q) + 13'(s2_dx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            pixel_addr   <= '0;
            deriv_select <= '0;
            alien_id     <= '0;
        end else begin
            valid        <= s2_valid_q;
            pixel_addr   <= s2_valid_q ? ADDR_W'(addr_full) : '0;
            deriv_select <= s2_valid_q ? s2_deriv_q : 2'b00;
            alien_id     <= s2_valid_q ? s2_idx_q : '0;
        end
    end

endmodule

// File: tb/tb_multi_alien_renderer.sv
// Scoreboard bench for multi_alien_renderer: driver queues expectations, monitor checks them.
module tb_multi_alien_renderer;
    import multi_alien_renderer_pkg::*;

    localparam int NA = 8;
    localparam int MH = 32;

    typedef struct {
        int due;
        int h;
        int v;
        bit vld;
        int addr;
        int deriv;
        int id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    alien_data_t   ad [NA];
    logic [NA-1:0] act;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [10:0]   pixel_addr;
    logic [1:0]    deriv_select;
    logic [2:0]    alien_id;
    logic          valid;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sbq[$];

    // Reference copy of the snapshot the DUT should currently be using.
    int m_x [NA];
    int m_y [NA];
    int m_r [NA];
    int m_dl[NA];
    int m_dr[NA];
    bit m_act[NA];

    multi_alien_renderer #(
        .N_ALIENS (NA),
        .MAX_HALF (MH),
        .ADDR_W   (11)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .alien_data   (ad),
        .alien_active (act),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .pixel_addr   (pixel_addr),
        .deriv_select (deriv_select),
        .alien_id     (alien_id),
        .valid        (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        int   best;
        e = '{default: 0};
        e.h = h;
        e.v = v;
        best = -1;
        for (int i = 0; i < NA; i++) begin
            int hw, dx, top, dy;
            if (!m_act[i] || m_r[i] >= MH) continue;
            hw  = MH - m_r[i];
            dx  = (h >= m_x[i]) ? h - m_x[i] : m_x[i] - h;
            top = m_y[i] - hw;
            dy  = v - top;
            if (dx >= hw || dy < 0 || dy >= 2 * hw) continue;
`ifdef ALIEN_DEPTH_SORT_EN
            if (best >= 0 && m_r[i] >= m_r[best]) continue;
`else
            if (best >= 0) continue;
`endif
            best    = i;
            e.vld   = 1'b1;
            e.addr  = (dy * hw + dx) % 2048;
            e.deriv = (h >= m_x[i]) ? m_dr[i] : m_dl[i];
            e.id    = i;
        end
        return e;
    endfunction

    function automatic exp_t fixed(input bit vld, input int addr, input int deriv, input int id);
        exp_t e;
        e = '{default: 0};
        e.vld = vld; e.addr = addr; e.deriv = deriv; e.id = id;
        return e;
    endfunction

    function automatic int clamp(input int a, input int lo, input int hi);
        return (a < lo) ? lo : ((a > hi) ? hi : a);
    endfunction

    task automatic set_alien(input int i, input int x, input int y, input int r,
                             input int dl, input int dr);
        ad[i]._x_pos       = 10'(x);
        ad[i]._y_pos       = 10'(y);
        ad[i]._r           = 6'(r);
        ad[i]._deriv_left  = 2'(dl);
        ad[i]._deriv_right = 2'(dr);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NA; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_r[i] = 0; m_dl[i] = 0; m_dr[i] = 0; m_act[i] = 1'b0;
        end
    endtask

    // One pixel per call; a frame_start pixel still sees the previous snapshot.
    task automatic drive(input int h, input int v, input bit fs, input bit use_model,
                         input exp_t ef);
        exp_t e;
        @(posedge clk);
        #1;
        h_cnt       = 10'(h);
        v_cnt       = 10'(v);
        frame_start = fs;
        e     = use_model ? model(h, v) : ef;
        e.h   = h;
        e.v   = v;
        e.due = cyc + int'(RENDER_LATENCY);
        sbq.push_back(e);
        if (fs) begin
            for (int i = 0; i < NA; i++) begin
                m_x[i]  = int'(ad[i]._x_pos);
                m_y[i]  = int'(ad[i]._y_pos);
                m_r[i]  = int'(ad[i]._r);
                m_dl[i] = int'(ad[i]._deriv_left);
                m_dr[i] = int'(ad[i]._deriv_right);
                m_act[i] = act[i];
            end
        end
    endtask

    task automatic check_outputs(input string name, input bit vld, input int addr);
        total++;
        if (valid !== vld || pixel_addr !== 11'(addr) || deriv_select !== 2'b00 && !vld
            || alien_id !== 3'b000 && !vld) begin
            bad++;
            $display("FAIL %s: got valid=%0b addr=%0d deriv=%0d id=%0d, want valid=%0b addr=%0d",
                     name, valid, pixel_addr, deriv_select, alien_id, vld, addr);
        end
    endtask

    // Monitor: compares every queued expectation in the cycle it falls due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                total++;
                bad++;
                $display("FAIL missed pixel (%0d,%0d) due=%0d now=%0d", e.h, e.v, e.due, cyc);
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                total++;
                if (valid !== e.vld || pixel_addr !== 11'(e.addr) ||
                    deriv_select !== 2'(e.deriv) || alien_id !== 3'(e.id)) begin
                    bad++;
                    $display("FAIL pixel (%0d,%0d): got valid=%0b addr=%0d deriv=%0d id=%0d, want valid=%0b addr=%0d deriv=%0d id=%0d",
                             e.h, e.v, valid, pixel_addr, deriv_select, alien_id,
                             e.vld, e.addr, e.deriv, e.id);
                end
            end
        end
    end

    initial begin
        exp_t z;
        z = fixed(1'b0, 0, 0, 0);
        rst_n = 1'b0; frame_start = 1'b0; h_cnt = '0; v_cnt = '0; act = '0;
        for (int i = 0; i < NA; i++) set_alien(i, 0, 0, 0, 0, 0);
        clear_model();
        #2;
        check_outputs("reset", 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Live data present but never snapshotted: nothing may be drawn.
        for (int i = 0; i < NA; i++) set_alien(i, 40 + 80 * i, 60 + 50 * i, i, 1, 2);
        act = '1;
        for (int v = 0; v < 480; v += 16)
            for (int h = 0; h < 640; h += 16) drive(h, v, 1'b0, 1'b0, z);

        // Single alien, both sides and right edge.
        for (int i = 0; i < NA; i++) set_alien(i, 0, 0, 0, 0, 0);
        set_alien(0, 100, 100, 0, 2, 1);
        act = 8'b0000_0001;
        drive(0, 479, 1'b1, 1'b0, z);
        drive(110, 80, 1'b0, 1'b0, fixed(1'b1, 394, 1, 0));
        drive(90, 80, 1'b0, 1'b0, fixed(1'b1, 394, 2, 0));
        drive(132, 80, 1'b0, 1'b0, z);
        drive(100, 100, 1'b0, 1'b0, fixed(1'b1, 1024, 1, 0));

        // r = MAX_HALF is invisible.
        set_alien(0, 100, 100, 32, 2, 1);
        drive(110, 80, 1'b1, 1'b0, fixed(1'b1, 394, 1, 0));
        drive(110, 80, 1'b0, 1'b0, z);
        drive(100, 100, 1'b0, 1'b0, z);

        // Sprite straddling the top edge.
        set_alien(0, 100, 10, 0, 2, 1);
        drive(0, 479, 1'b1, 1'b0, z);
        drive(100, 0, 1'b0, 1'b0, fixed(1'b1, 704, 1, 0));

        // Overlap between ch0 (r=8) and ch3 (r=2).
        set_alien(0, 200, 200, 8, 2, 1);
        set_alien(3, 200, 200, 2, 0, 3);
        act = 8'b0000_1001;
        drive(0, 479, 1'b1, 1'b0, z);
`ifdef ALIEN_DEPTH_SORT_EN
        drive(200, 200, 1'b0, 1'b0, fixed(1'b1, 900, 3, 3));
`else
        drive(200, 200, 1'b0, 1'b0, fixed(1'b1, 576, 1, 0));
`endif
        set_alien(3, 200, 200, 8, 0, 3);
        drive(0, 479, 1'b1, 1'b0, z);
        drive(200, 200, 1'b0, 1'b0, fixed(1'b1, 576, 1, 0));

        // Mid-frame edits are invisible until the next frame_start.
        set_alien(3, 0, 0, 0, 0, 0);
        set_alien(0, 100, 100, 0, 2, 1);
        act = 8'b0000_0001;
        drive(0, 479, 1'b1, 1'b0, z);
        drive(110, 80, 1'b0, 1'b0, fixed(1'b1, 394, 1, 0));
        set_alien(0, 300, 100, 0, 2, 1);
        drive(110, 80, 1'b0, 1'b0, fixed(1'b1, 394, 1, 0));
        drive(110, 80, 1'b1, 1'b0, fixed(1'b1, 394, 1, 0));
        drive(110, 80, 1'b0, 1'b0, z);
        drive(310, 80, 1'b0, 1'b0, fixed(1'b1, 394, 1, 0));

        // Asynchronous reset while a hit is on the outputs.
        repeat (4) drive(310, 80, 1'b0, 1'b1, z);
        @(posedge clk);
        #3;
        check_outputs("valid_before_reset", 1'b1, 394);
        rst_n = 1'b0;
        sbq.delete();
        clear_model();
        #1;
        check_outputs("reset_mid_line", 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(310, 80, 1'b0, 1'b0, z);
        drive(310, 80, 1'b1, 1'b1, z);
        for (int i = 0; i < 4; i++) drive(310 - 2 * i, 80 + i, 1'b0, 1'b1, z);

        // Randomised frames with clustered aliens to exercise overlaps.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NA; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0)
                    set_alien(i, clamp(int'(ad[i-1]._x_pos) + int'($urandom_range(0, 20)) - 10, 0, 639),
                              clamp(int'(ad[i-1]._y_pos) + int'($urandom_range(0, 20)) - 10, 0, 479),
                              $urandom_range(0, 34), $urandom_range(0, 3), $urandom_range(0, 3));
                else
                    set_alien(i, $urandom_range(0, 639), $urandom_range(0, 479),
                              $urandom_range(0, 34), $urandom_range(0, 3), $urandom_range(0, 3));
                act[i] = ($urandom_range(0, 3) != 0);
            end
            drive($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1, z);
            for (int p = 0; p < 300; p++) begin
                int c, h, v;
                c = $urandom_range(0, NA - 1);
                h = clamp(int'(ad[c]._x_pos) + int'($urandom_range(0, 70)) - 35, 0, 1023);
                v = clamp(int'(ad[c]._y_pos) + int'($urandom_range(0, 70)) - 35, 0, 1023);
                drive(h, v, 1'b0, 1'b1, z);
            end
        end

        repeat (6) @(posedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_alien_renderer.md
# multi_alien_renderer

Pipelined, multi-channel sprite-address generator for the alien layer of the VGA frame. For each screen pixel (h_cnt, v_cnt) it tests up to N_ALIENS alien descriptors in parallel. It picks one winner per pixel and outputs that alien's sprite ROM address, derivative (pose) select and ID. It sits between the game-state logic, which supplies the AlienData array, and the sprite ROM / pixel mux. Descriptors are snapshotted once per frame so sprites never tear mid-frame.

## Interface
- N_ALIENS, 8: number of alien channels tested per pixel (1..16).
- MAX_HALF, 32: half-size of a sprite at _r = 0; drawn halfwidth = MAX_HALF - _r.
- ADDR_W, 11: sprite ROM address width.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vblank; latches the descriptor snapshot.
- alien_data  in  AlienData[N_ALIENS]  live descriptors (_x_pos, _y_pos, _r, _deriv_left, _deriv_right).
- alien_active  in  N_ALIENS  per-channel enable, latched with alien_data.
- h_cnt  in  10  current pixel column.
- v_cnt  in  10  current pixel row.
- pixel_addr  out  ADDR_W  sprite ROM address of the winning alien.
- deriv_select  out  2  pose select of the winner.
- alien_id  out  $clog2(N_ALIENS) (min 1)  index of the winner.
- valid  out  1  a winner exists for this pixel.

## Operation
- Snapshot: on a clk edge with frame_start = 1, shadow_data <= alien_data and shadow_active <= alien_active. All hit tests use only shadow values.
- Per channel i, the hit test uses shadow values:
  - hw = MAX_HALF - _r in 10 bits. The channel is invisible if _r >= MAX_HALF or shadow_active[i] = 0.
  - Side: right if h_cnt >= _x_pos, so dx = h_cnt - _x_pos. Left (mirrored) otherwise, so dx = _x_pos - h_cnt.
  - Horizontal hit: dx < hw. On the left side dx >= 1 always, so column _x_pos is drawn once.
  - Vertical: top = _y_pos - hw, evaluated as 11-bit signed; a negative top is clipped, never wrapped. dy = v_cnt - top. Vertical hit: 0 <= dy < 2*hw.
  - Hit = visible and horizontal hit and vertical hit.
  - deriv = _deriv_right on the right side, _deriv_left on the left side.
- Winner: the lowest-index hitting channel, unless the depth sort is enabled (see Configuration).
- Address: pixel_addr = dy*hw + dx, computed at full width (max 63*32 + 31 = 2047) and truncated to ADDR_W.
- No hit: valid = 0, and pixel_addr, deriv_select and alien_id are forced to 0.

## Timing
- The pipeline has 3 stages with fixed latency 3. Outputs at cycle t correspond to the h_cnt/v_cnt sampled at cycle t-3. No stall or backpressure; a new pixel is accepted every cycle.
  - S1: per-channel hit, dx, dy, hw and deriv are registered.
  - S2: winner selection; the winner's index, dx, dy, hw and deriv are registered.
  - S3: multiply-add, then the outputs are registered.
- Reset (asynchronous, rst_n = 0): shadow_active = 0, all pipeline registers = 0, and valid, pixel_addr, deriv_select, alien_id = 0.
  - After release, valid stays 0 until the first frame_start has been seen.
  - Reset asserted mid-line clears everything immediately. Stale pixels are never emitted.
- frame_start coinciding with an active pixel: the new snapshot applies to S1 from the next cycle. Pixels already in S2/S3 finish with the old snapshot. This is legal; the game logic pulses frame_start in vblank only.
- Simultaneous hits: exactly one winner per the priority rule. Ties always resolve to the lower index.

## Configuration
- ALIEN_DEPTH_SORT_EN defined: the winner is the hitting channel with the smallest _r (closest alien). Ties go to the lower index. The S2 priority uses a comparator tree; latency is still 3.
- ALIEN_DEPTH_SORT_EN undefined: the winner is the lowest-index hitting channel (fixed priority encoder).

## Structure
- constants.svh: MAX_HALF default, ADDR_W default, RENDER_LATENCY = 3.
- typedefs.svh: the existing AlienData, plus a new AlienHit struct (hit, dx[5:0], dy[6:0], hw[5:0], deriv[1:0], r) carried from S1 to S2.
- Sub-module alien_hit_unit: combinational S1 hit test for one channel, generated N_ALIENS times. Stage registers live in multi_alien_renderer.

## Test plan
- Reset, then no frame_start -> valid = 0 for a full 640x480 sweep.
- One alien, ch0 {x=100, y=100, r=0, deriv_r=1, deriv_l=2}, active:
  - At pixel (110, 80), three cycles later -> valid = 1, pixel_addr = 12*32 + 10 = 394, deriv_select = 1.
  - At (90, 80) -> pixel_addr = 394, deriv_select = 2.
  - At (132, 80) -> valid = 0.
- ch0 with r = 32 -> never valid. ch0 with y = 10, r = 0 at pixel (100, 0) -> dy = 22, addr = 704, so no wrap at the top edge.
- Overlap: ch0 {r=8} and ch3 {r=2} both cover (200, 200):
  - With the macro: alien_id = 3.
  - Without the macro: alien_id = 0.
  - Equal r with the macro: alien_id = 0.
- Change alien_data mid-frame without frame_start -> outputs unchanged. After the frame_start pulse, the new positions appear from the 4th cycle onward.
- Assert rst_n = 0 mid-line while valid = 1 -> valid = 0 within the same cycle, and stays 0 until a new frame_start.
